// File: rtl/rob_retire_pkg.sv
// Shared constants and the entry record for the in-order retirement buffer.
package rob_pkg;
   localparam int DEPTH  = 8;
   localparam int TAG_W  = 3;
   localparam int DATA_W = 32;
   localparam int RA_W   = 3;
   localparam int FLAG_W = 5;
   localparam int PTR_W  = TAG_W + 1;
   localparam int NPORT  = 3;

   typedef struct packed {
      logic              valid;
      logic              done;
      logic              we;
      logic              fe;
      logic [RA_W-1:0]   wa;
      logic [DATA_W-1:0] wd;
      logic [FLAG_W-1:0] fd;
   } rob_entry_t;
endpackage

// File: rtl/rob_retire_if.sv
// Issue/completion inputs and RF write-port outputs of the retirement buffer.
interface rob_retire_if;
   import rob_pkg::*;

   logic              ALLOC_VALID;
   logic              ALLOC_READY;
   logic [RA_W-1:0]   ALLOC_WA;
   logic              ALLOC_WE;
   logic              ALLOC_FE;
   logic [TAG_W-1:0]  ALLOC_TAG;
   logic [NPORT-1:0]  CMP_VALID;
   logic [TAG_W-1:0]  CMP_TAG [NPORT];
   logic [DATA_W-1:0] CMP_WD  [NPORT];
   logic [FLAG_W-1:0] CMP_FD  [NPORT];
   logic [RA_W-1:0]   WA1, WA2, WA3;
   logic [DATA_W-1:0] WD1, WD2, WD3;
   logic              WE1, WE2, WE3;
   logic [FLAG_W-1:0] WDF1, WDF2;
   logic              WEF1, WEF2;
   logic [PTR_W-1:0]  COUNT;
   logic              ERR;

   modport slave (
      input  ALLOC_VALID, ALLOC_WA, ALLOC_WE, ALLOC_FE,
      input  CMP_VALID, CMP_TAG, CMP_WD, CMP_FD,
      output ALLOC_READY, ALLOC_TAG,
      output WA1, WA2, WA3, WD1, WD2, WD3, WE1, WE2, WE3,
      output WDF1, WDF2, WEF1, WEF2, COUNT, ERR
   );

   modport master (
      output ALLOC_VALID, ALLOC_WA, ALLOC_WE, ALLOC_FE,
      output CMP_VALID, CMP_TAG, CMP_WD, CMP_FD,
      input  ALLOC_READY, ALLOC_TAG,
      input  WA1, WA2, WA3, WD1, WD2, WD3, WE1, WE2, WE3,
      input  WDF1, WDF2, WEF1, WEF2, COUNT, ERR
   );
endinterface

// File: rtl/rob_retire_sel.sv
// Picks up to three consecutive completed entries from head and maps them onto
// RF write ports (oldest -> port 3) and flag ports (youngest flag writer -> port 1).
module rob_retire_sel
   import rob_pkg::*;
(
   input  rob_entry_t        win   [NPORT],
   output logic [1:0]        n,
   output logic [NPORT-1:0]  wr_en,
   output logic [RA_W-1:0]   wr_wa [NPORT],
   output logic [DATA_W-1:0] wr_wd [NPORT],
   output logic [1:0]        fl_en,
   output logic [FLAG_W-1:0] fl_d  [2]
);

   logic [NPORT-1:0] ret;

   always_comb begin
      ret   = '0;
      wr_en = '0;
      fl_en = '0;
      for (int f = 0; f < 2; f++) fl_d[f] = '0;

      ret[0] = win[0].valid && win[0].done;
      ret[1] = ret[0] && win[1].valid && win[1].done;
      ret[2] = ret[1] && win[2].valid && win[2].done;
      n = {1'b0, ret[0]} + {1'b0, ret[1]} + {1'b0, ret[2]};

      // port index p (port p+1) carries window slot 2-p
      for (int p = 0; p < NPORT; p++) begin
         wr_en[p] = ret[2-p] && win[2-p].we;
         wr_wa[p] = win[2-p].wa;
         wr_wd[p] = win[2-p].wd;
      end

      for (int k = NPORT - 1; k >= 0; k--) begin
         if (ret[k] && win[k].fe) begin
            if (!fl_en[0]) begin
               fl_en[0] = 1'b1;
               fl_d[0]  = win[k].fd;
            end else if (!fl_en[1]) begin
               fl_en[1] = 1'b1;
               fl_d[1]  = win[k].fd;
            end
         end
      end
   end

endmodule

// File: rtl/rob_retire.sv
// In-order retirement buffer: entry array, pointers, completion capture and
// registered RF write/flag ports.
module rob_retire
   import rob_pkg::*;
(
   input  logic        CLK,
   input  logic        N_RST,
   input  logic        FLUSH,
   rob_retire_if.slave bus
);

   rob_entry_t        ent [DEPTH];
   logic [PTR_W-1:0]  head, tail;
   logic [TAG_W-1:0]  head_idx, tail_idx;
   logic              full, do_alloc, err;

   rob_entry_t        win     [NPORT];
   logic [TAG_W-1:0]  win_idx [NPORT];
   logic [1:0]        sel_n;
   logic [NPORT-1:0]  wr_en;
   logic [RA_W-1:0]   wr_wa [NPORT];
   logic [DATA_W-1:0] wr_wd [NPORT];
   logic [1:0]        fl_en;
   logic [FLAG_W-1:0] fl_d  [2];

   logic [NPORT-1:0]  cmp_ok, dup;
   logic              cmp_err;

   logic [NPORT-1:0]  we_q;
   logic [RA_W-1:0]   wa_q  [NPORT];
   logic [DATA_W-1:0] wd_q  [NPORT];
   logic [1:0]        wef_q;
   logic [FLAG_W-1:0] wdf_q [2];

   assign head_idx = head[TAG_W-1:0];
   assign tail_idx = tail[TAG_W-1:0];
   assign full     = (head[TAG_W] != tail[TAG_W]) && (head_idx == tail_idx);
   assign do_alloc = bus.ALLOC_VALID && !full;

   always_comb begin
      for (int k = 0; k < NPORT; k++) begin
         win_idx[k] = head_idx + TAG_W'(k);
         win[k]     = ent[win_idx[k]];
      end
   end

   rob_retire_sel u_sel (
      .win   (win),
      .n     (sel_n),
      .wr_en (wr_en),
      .wr_wa (wr_wa),
      .wr_wd (wr_wd),
      .fl_en (fl_en),
      .fl_d  (fl_d)
   );

   // lower port index wins a same-tag collision; the loser only raises ERR
   always_comb begin
      cmp_ok  = '0;
      cmp_err = 1'b0;
      dup     = '0;
      dup[1]  = bus.CMP_VALID[0] && (bus.CMP_TAG[0] == bus.CMP_TAG[1]);
      dup[2]  = (bus.CMP_VALID[0] && (bus.CMP_TAG[0] == bus.CMP_TAG[2])) ||
                (bus.CMP_VALID[1] && (bus.CMP_TAG[1] == bus.CMP_TAG[2]));
      for (int i = 0; i < NPORT; i++) begin
         if (bus.CMP_VALID[i]) begin
            if (dup[i] || !ent[bus.CMP_TAG[i]].valid || ent[bus.CMP_TAG[i]].done)
               cmp_err = 1'b1;
            else
               cmp_ok[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge N_RST) begin
      if (!N_RST) begin
         for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
         head  <= '0;
         tail  <= '0;
         err   <= 1'b0;
         we_q  <= '0;
         wef_q <= '0;
         for (int p = 0; p < NPORT; p++) begin
            wa_q[p] <= '0;
            wd_q[p] <= '0;
         end
         for (int f = 0; f < 2; f++) wdf_q[f] <= '0;
      end else if (FLUSH) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent[i].valid <= 1'b0;
            ent[i].done  <= 1'b0;
         end
         head  <= '0;
         tail  <= '0;
         we_q  <= '0;
         wef_q <= '0;
      end else begin
         // alloc, completion and retire never target the same entry
         if (do_alloc) begin
            ent[tail_idx].valid <= 1'b1;
            ent[tail_idx].done  <= 1'b0;
            ent[tail_idx].we    <= bus.ALLOC_WE;
            ent[tail_idx].fe    <= bus.ALLOC_FE;
            ent[tail_idx].wa    <= bus.ALLOC_WA;
         end
         for (int i = 0; i < NPORT; i++) begin
            if (cmp_ok[i]) begin
               ent[bus.CMP_TAG[i]].wd   <= bus.CMP_WD[i];
               ent[bus.CMP_TAG[i]].fd   <= bus.CMP_FD[i];
               ent[bus.CMP_TAG[i]].done <= 1'b1;
            end
         end
         for (int k = 0; k < NPORT; k++) begin
            if (2'(k) < sel_n) begin
               ent[win_idx[k]].valid <= 1'b0;
               ent[win_idx[k]].done  <= 1'b0;
            end
         end
         head <= head + PTR_W'(sel_n);
         tail <= tail + PTR_W'(do_alloc);
         err  <= err | cmp_err;

         we_q <= wr_en;
         for (int p = 0; p < NPORT; p++) begin
            if (wr_en[p]) begin
               wa_q[p] <= wr_wa[p];
               wd_q[p] <= wr_wd[p];
            end
         end
         wef_q <= fl_en;
         for (int f = 0; f < 2; f++) begin
            if (fl_en[f]) wdf_q[f] <= fl_d[f];
         end
      end
   end

   assign bus.ALLOC_READY = !full;
   assign bus.ALLOC_TAG   = tail_idx;
   assign bus.COUNT       = tail - head;
   assign bus.ERR         = err;
   assign bus.WE1  = we_q[0];
   assign bus.WE2  = we_q[1];
   assign bus.WE3  = we_q[2];
   assign bus.WA1  = wa_q[0];
   assign bus.WA2  = wa_q[1];
   assign bus.WA3  = wa_q[2];
   assign bus.WD1  = wd_q[0];
   assign bus.WD2  = wd_q[1];
   assign bus.WD3  = wd_q[2];
   assign bus.WEF1 = wef_q[0];
   assign bus.WEF2 = wef_q[1];
   assign bus.WDF1 = wdf_q[0];
   assign bus.WDF2 = wdf_q[1];

endmodule

// File: tb/tb_rob_retire.sv
// Directed bench for rob_retire with a small RF model on the write ports.
module tb_rob_retire;
   logic CLK;
   logic N_RST;
   logic FLUSH;
   int   total;
   int   bad;

   rob_retire_if bus();

   rob_retire dut (
      .CLK   (CLK),
      .N_RST (N_RST),
      .FLUSH (FLUSH),
      .bus   (bus.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic [31:0] rf [8];
   logic [4:0]  rf_flags;

   // port 1 written last so the youngest retiring entry wins
   always @(posedge CLK) begin
      if (bus.WE3)  rf[bus.WA3] = bus.WD3;
      if (bus.WE2)  rf[bus.WA2] = bus.WD2;
      if (bus.WE1)  rf[bus.WA1] = bus.WD1;
      if (bus.WEF2) rf_flags = bus.WDF2;
      if (bus.WEF1) rf_flags = bus.WDF1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic clr_cmp();
      bus.CMP_VALID = '0;
      for (int i = 0; i < 3; i++) begin
         bus.CMP_TAG[i] = '0;
         bus.CMP_WD[i]  = '0;
         bus.CMP_FD[i]  = '0;
      end
   endtask

   task automatic do_reset();
      N_RST           = 1'b0;
      FLUSH           = 1'b0;
      bus.ALLOC_VALID = 1'b0;
      bus.ALLOC_WA    = '0;
      bus.ALLOC_WE    = 1'b0;
      bus.ALLOC_FE    = 1'b0;
      clr_cmp();
      #2;
      N_RST = 1'b1;
   endtask

   task automatic alloc(input logic [2:0] wa, input logic we, input logic fe);
      bus.ALLOC_VALID = 1'b1;
      bus.ALLOC_WA    = wa;
      bus.ALLOC_WE    = we;
      bus.ALLOC_FE    = fe;
      step();
      bus.ALLOC_VALID = 1'b0;
   endtask

   task automatic cmp(input int port, input logic [2:0] tag, input logic [31:0] wd, input logic [4:0] fd);
      bus.CMP_VALID[port] = 1'b1;
      bus.CMP_TAG[port]   = tag;
      bus.CMP_WD[port]    = wd;
      bus.CMP_FD[port]    = fd;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      total = 0;
      bad   = 0;
      N_RST = 1'b0;
      FLUSH = 1'b0;
      @(posedge CLK);
      #1;

      // 1: three completions in one cycle retire together, oldest on port 3
      do_reset();
      chk("rst_count", bus.COUNT, 0);
      chk("rst_ready", bus.ALLOC_READY, 1);
      chk("rst_tag",   bus.ALLOC_TAG, 0);
      chk("rst_err",   bus.ERR, 0);
      chk("rst_we3",   bus.WE3, 0);
      chk("rst_wa1",   bus.WA1, 0);
      alloc(3'd1, 1'b1, 1'b0);
      alloc(3'd2, 1'b1, 1'b0);
      alloc(3'd3, 1'b1, 1'b0);
      chk("t1_count3", bus.COUNT, 3);
      chk("t1_tag3",   bus.ALLOC_TAG, 3);
      cmp(0, 3'd2, 32'h102, 5'd0);
      cmp(1, 3'd1, 32'h101, 5'd0);
      cmp(2, 3'd0, 32'h100, 5'd0);
      step();
      clr_cmp();
      chk("t1_we3_early", bus.WE3, 0);
      chk("t1_count_pre", bus.COUNT, 3);
      step();
      chk("t1_we3", bus.WE3, 1);
      chk("t1_wa3", bus.WA3, 1);
      chk("t1_wd3", bus.WD3, 32'h100);
      chk("t1_we2", bus.WE2, 1);
      chk("t1_wa2", bus.WA2, 2);
      chk("t1_we1", bus.WE1, 1);
      chk("t1_wa1", bus.WA1, 3);
      chk("t1_wd1", bus.WD1, 32'h102);
      chk("t1_count0", bus.COUNT, 0);
      step();
      chk("t1_we3_off", bus.WE3, 0);
      chk("t1_wa3_hold", bus.WA3, 1);

      // 2: same-address pair with flags
      do_reset();
      alloc(3'd5, 1'b1, 1'b1);
      alloc(3'd5, 1'b1, 1'b1);
      cmp(0, 3'd0, 32'hA, 5'd1);
      cmp(1, 3'd1, 32'hB, 5'd2);
      step();
      clr_cmp();
      step();
      chk("t2_wa3", bus.WA3, 5);
      chk("t2_wd3", bus.WD3, 32'hA);
      chk("t2_wa2", bus.WA2, 5);
      chk("t2_wd2", bus.WD2, 32'hB);
      chk("t2_we1", bus.WE1, 0);
      chk("t2_wef1", bus.WEF1, 1);
      chk("t2_wdf1", bus.WDF1, 2);
      chk("t2_wef2", bus.WEF2, 1);
      chk("t2_wdf2", bus.WDF2, 1);
      step();
      chk("t2_rf5",   rf[5], 32'hB);
      chk("t2_flags", rf_flags, 2);

      // 3: younger completes first, waits for head
      do_reset();
      alloc(3'd6, 1'b1, 1'b0);
      alloc(3'd7, 1'b1, 1'b0);
      cmp(0, 3'd1, 32'h71, 5'd0);
      step();
      clr_cmp();
      step();
      chk("t3_we3_wait", bus.WE3, 0);
      chk("t3_we2_wait", bus.WE2, 0);
      chk("t3_count2", bus.COUNT, 2);
      cmp(1, 3'd0, 32'h60, 5'd0);
      step();
      clr_cmp();
      chk("t3_we3_early", bus.WE3, 0);
      step();
      chk("t3_we3", bus.WE3, 1);
      chk("t3_wa3", bus.WA3, 6);
      chk("t3_we2", bus.WE2, 1);
      chk("t3_wa2", bus.WA2, 7);
      chk("t3_count0", bus.COUNT, 0);

      // 4: full buffer, rejected alloc, wrap
      do_reset();
      for (int i = 0; i < 8; i++) alloc(3'(i), 1'b1, 1'b0);
      chk("t4_ready_full", bus.ALLOC_READY, 0);
      chk("t4_count8", bus.COUNT, 8);
      alloc(3'd0, 1'b1, 1'b0);
      chk("t4_count_9th", bus.COUNT, 8);
      chk("t4_tag_full", bus.ALLOC_TAG, 0);
      cmp(0, 3'd0, 32'h40, 5'd0);
      step();
      clr_cmp();
      chk("t4_ready_sel", bus.ALLOC_READY, 0);
      step();
      chk("t4_ready_back", bus.ALLOC_READY, 1);
      chk("t4_count7", bus.COUNT, 7);
      chk("t4_we3", bus.WE3, 1);
      chk("t4_wa3", bus.WA3, 0);
      chk("t4_tag_wrap", bus.ALLOC_TAG, 0);
      alloc(3'd7, 1'b1, 1'b0);
      chk("t4_tag_next", bus.ALLOC_TAG, 1);
      chk("t4_ready_again", bus.ALLOC_READY, 0);

      // 5: double completion keeps first data; unallocated tag; same-tag ports
      do_reset();
      for (int i = 0; i < 5; i++) alloc(3'(i + 1), 1'b1, 1'b0);
      cmp(0, 3'd4, 32'h44, 5'd0);
      step();
      clr_cmp();
      chk("t5_err_clean", bus.ERR, 0);
      cmp(1, 3'd4, 32'h55, 5'd0);
      step();
      clr_cmp();
      chk("t5_err_dup", bus.ERR, 1);
      cmp(0, 3'd0, 32'h10, 5'd0);
      cmp(1, 3'd1, 32'h11, 5'd0);
      cmp(2, 3'd2, 32'h12, 5'd0);
      step();
      clr_cmp();
      cmp(0, 3'd3, 32'h13, 5'd0);
      step();
      clr_cmp();
      step();
      chk("t5_wa3", bus.WA3, 4);
      chk("t5_wd2_kept", bus.WD2, 32'h44);
      chk("t5_we1", bus.WE1, 0);
      do_reset();
      cmp(0, 3'd6, 32'h66, 5'd0);
      step();
      clr_cmp();
      chk("t5_err_unalloc", bus.ERR, 1);
      do_reset();
      alloc(3'd2, 1'b1, 1'b0);
      cmp(0, 3'd0, 32'h11, 5'd0);
      cmp(2, 3'd0, 32'h22, 5'd0);
      step();
      clr_cmp();
      chk("t5_err_sametag", bus.ERR, 1);
      step();
      chk("t5_we3_win", bus.WE3, 1);
      chk("t5_wd3_win", bus.WD3, 32'h11);

      // 6: flush suppresses pending retire; reset clears outputs at once
      do_reset();
      for (int i = 0; i < 5; i++) alloc(3'(i), 1'b1, 1'b0);
      cmp(0, 3'd0, 32'h20, 5'd0);
      cmp(1, 3'd1, 32'h21, 5'd0);
      step();
      clr_cmp();
      FLUSH           = 1'b1;
      bus.ALLOC_VALID = 1'b1;
      cmp(0, 3'd2, 32'h22, 5'd0);
      step();
      FLUSH           = 1'b0;
      bus.ALLOC_VALID = 1'b0;
      clr_cmp();
      chk("t6_we3", bus.WE3, 0);
      chk("t6_we2", bus.WE2, 0);
      chk("t6_count", bus.COUNT, 0);
      chk("t6_tag", bus.ALLOC_TAG, 0);
      chk("t6_err", bus.ERR, 0);
      step();
      chk("t6_we3_after", bus.WE3, 0);
      alloc(3'd3, 1'b1, 1'b0);
      cmp(0, 3'd0, 32'h33, 5'd0);
      step();
      clr_cmp();
      step();
      chk("t6_we3_pre_rst", bus.WE3, 1);
      chk("t6_wa3_pre_rst", bus.WA3, 3);
      N_RST = 1'b0;
      #1;
      chk("t6_rst_we3", bus.WE3, 0);
      chk("t6_rst_wa3", bus.WA3, 0);
      chk("t6_rst_wd3", bus.WD3, 0);
      chk("t6_rst_count", bus.COUNT, 0);
      N_RST = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
